spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 32, frame length in bits (legal 8..32).
REQ-002 SHALL have port avmm_clk  input  1  single clock for all logic.
REQ-003 SHALL have port avmm_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port avmm_cs  input  1  register-bus select; access only when high.
REQ-005 SHALL have port avmm_addr  input  2  register address.
REQ-006 SHALL have port avmm_write  input  1  write strobe, qualified by avmm_cs.
REQ-007 SHALL have port avmm_writedata  input  32  write data.
REQ-008 SHALL have port avmm_read  input  1  read strobe, qualified by avmm_cs.
REQ-009 SHALL have port avmm_readdata  output  32  read data, registered.
REQ-010 SHALL have port spi_clk  input  1  SPI clock from the controller, asynchronous.
REQ-011 SHALL have port spi_cs_n  input  1  SPI select, active low, asynchronous.
REQ-012 SHALL have port spi_mosi  input  1  serial data in, asynchronous.
REQ-013 SHALL have port spi_miso  output  1  serial data out, always driven (no tristate).

Function
REQ-014 SHALL pass spi_clk, spi_cs_n and spi_mosi through 2-flop synchronizers, plus one edge-detect register; SPI mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-015 SHALL support spi_clk high/low phases of at least 4 avmm_clk cycles; faster clocks are unsupported.
REQ-016 SHALL implement register map: addr0 STATUS (RO/W1C), addr1 RXDATA (RO), addr2 TXDATA (WO), addr3 FRAMECNT (RO; any write clears).
REQ-017 STATUS bits: [0] rx_valid, [1] overrun (sticky, W1C), [2] busy (state != IDLE), [3] tx_loaded, [4] underrun (sticky, W1C); bits 31:5 read 0.
REQ-018 SHALL return avmm_readdata one cycle after an accepted read (fixed latency 1); it holds its value otherwise; unmapped/WO reads return 0.
REQ-019 Writing TXDATA SHALL store writedata[FRAME_BITS-1:0] in the TX buffer and set tx_loaded; a write during an active frame affects only the next frame.
REQ-020 State machine IDLE -> ACTIVE on synchronized spi_cs_n falling edge; ACTIVE -> DONE after FRAME_BITS sampled bits; ACTIVE or DONE -> IDLE on spi_cs_n rising edge.
REQ-021 On IDLE->ACTIVE SHALL load the shift register from the TX buffer and clear tx_loaded; if tx_loaded was 0, SHALL load all zeros and set underrun.
REQ-022 In ACTIVE, spi_miso SHALL equal shift MSB; on each synchronized spi_clk rising edge SHALL sample spi_mosi into shift LSB and increment the bit counter; on each falling edge SHALL shift left.
REQ-023 At the FRAME_BITS-th rising edge SHALL copy the received word to RXDATA (right-aligned, zero-extended), set rx_valid and increment FRAMECNT (16-bit, wraps at 0xFFFF->0).
REQ-024 If rx_valid is already 1 at completion, SHALL overwrite RXDATA and set overrun.
REQ-025 A read of RXDATA SHALL clear rx_valid, unless a frame completes the same cycle, in which case rx_valid stays 1 and overrun is not set.
REQ-026 spi_cs_n rising edge in ACTIVE before FRAME_BITS bits SHALL abort: discard partial data, no RXDATA/rx_valid/FRAMECNT update.
REQ-027 In DONE and IDLE spi_miso SHALL be 0 and extra spi_clk edges SHALL be ignored.
REQ-028 A W1C clear of overrun/underrun coinciding with a new set event SHALL leave the bit set.

Reset
REQ-029 On avmm_reset: state IDLE, avmm_readdata 0, spi_miso 0, shift/RXDATA/TX buffer 0, all STATUS bits 0, FRAMECNT 0, bit counter 0, synchronizers to idle (spi_cs_n=1, spi_clk=0).
REQ-030 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait for a fresh spi_cs_n falling edge before starting.

Verification
REQ-031 Write TXDATA=0x5A123456, send frame with MOSI 0x6881A5C3 -> MISO bits form 0x5A123456, RXDATA=0x6881A5C3, STATUS=0x1, FRAMECNT=1.
REQ-032 Two frames without reading RXDATA -> RXDATA holds second word, STATUS[1]=1; write STATUS 0x2 -> overrun cleared.
REQ-033 Frame with no TXDATA write -> MISO all zeros, underrun=1, received data still captured.
REQ-034 Raise spi_cs_n after 10 bits -> no rx_valid, FRAMECNT unchanged, next full frame received correctly.
REQ-035 RXDATA read in the same cycle as frame completion -> rx_valid=1, overrun=0; readdata valid exactly one cycle after read strobe.
REQ-036 Assert avmm_reset mid-frame -> all outputs/registers 0; following complete frame received correctly; FRAME_BITS=8 run: RXDATA=0x000000A5 for MOSI 0xA5.

Source files
------------

// File: rtl/spi_target.sv
// -----------------------------------------------------------------------------
// spi_target
//
// SPI target (mode 0: CPOL=0, CPHA=0, MSB first) with a small register
// interface. All logic runs on avmm_clk; the SPI pins are asynchronous and
// are brought into the avmm_clk domain through 2-flop synchronizers followed
// by one edge-detect register. The SPI clock must stay high and low for at
// least 4 avmm_clk cycles each.
//
// Register map (32-bit):
//   0 STATUS   RO/W1C  [0] rx_valid [1] overrun (W1C) [2] busy
//                      [3] tx_loaded [4] underrun (W1C)
//   1 RXDATA   RO      last received frame, right-aligned; reading clears
//                      rx_valid
//   2 TXDATA   WO      word shifted out in the next frame; reads return 0
//   3 FRAMECNT RO      16-bit completed-frame counter; any write clears it
//
// Ports:
//   avmm_clk        single clock for all logic
//   avmm_reset      synchronous, active-high reset
//   avmm_cs         register-bus select (qualifies read and write)
//   avmm_addr       register address
//   avmm_write      write strobe
//   avmm_writedata  write data
//   avmm_read       read strobe
//   avmm_readdata   read data, valid one cycle after an accepted read
//   spi_clk         SPI clock from the controller (asynchronous)
//   spi_cs_n        SPI select, active low (asynchronous)
//   spi_mosi        serial data in (asynchronous)
//   spi_miso        serial data out, always driven, 0 outside a frame
// -----------------------------------------------------------------------------
module spi_target #(
  parameter int FRAME_BITS = 32
) (
  input  logic        avmm_clk,
  input  logic        avmm_reset,
  input  logic        avmm_cs,
  input  logic [1:0]  avmm_addr,
  input  logic        avmm_write,
  input  logic [31:0] avmm_writedata,
  input  logic        avmm_read,
  output logic [31:0] avmm_readdata,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso
);

  localparam int CW = $clog2(FRAME_BITS + 1);

  localparam logic [1:0] ADDR_STATUS   = 2'd0;
  localparam logic [1:0] ADDR_RXDATA   = 2'd1;
  localparam logic [1:0] ADDR_TXDATA   = 2'd2;
  localparam logic [1:0] ADDR_FRAMECNT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] sclk_sync;
  logic [1:0] csn_sync;
  logic [1:0] mosi_sync;
  logic       sclk_d;
  logic       csn_d;
  logic [1:0] settle;

  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from pre-edge values; blocking assignments here
  // would make results depend on statement order and simulate differently
  // from the synthesized flops.
  always_ff @(posedge avmm_clk) begin
    if (avmm_reset) begin
      sclk_sync <= 2'b00;
      csn_sync  <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b1;
      settle    <= 2'd0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      csn_sync  <= {csn_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_d    <= sclk_sync[1];
      csn_d     <= csn_sync[1];
      if (settle != 2'd3) begin
        settle <= settle + 2'd1;
      end
    end
  end

  logic sclk_s;
  logic csn_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;
  logic settled;

  assign sclk_s    = sclk_sync[1];
  assign csn_s     = csn_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = csn_s & ~csn_d;
  // The synchronizer stages come out of reset holding "deselected". If the
  // controller is still holding spi_cs_n low, that stale 1 draining out would
  // look like a falling edge. Only trust a falling edge once every stage
  // (including the edge register) holds a real pin sample, so a frame cut by
  // reset is never resumed half way through.
  assign settled   = (settle == 2'd3);
  assign cs_fall   = settled & csn_d & ~csn_s;

  // ---------------------------------------------------------------------------
  // Register-bus decode
  // ---------------------------------------------------------------------------
  logic wr_en;
  logic rd_en;
  logic wr_status;
  logic wr_tx;
  logic wr_cnt;
  logic rd_rx;

  assign wr_en     = avmm_cs & avmm_write;
  assign rd_en     = avmm_cs & avmm_read;
  assign wr_status = wr_en && (avmm_addr == ADDR_STATUS);
  assign wr_tx     = wr_en && (avmm_addr == ADDR_TXDATA);
  assign wr_cnt    = wr_en && (avmm_addr == ADDR_FRAMECNT);
  assign rd_rx     = rd_en && (avmm_addr == ADDR_RXDATA);

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_t                  state;
  logic [FRAME_BITS-1:0]   shift;
  logic [CW-1:0]           bit_cnt;
  logic                    mosi_bit;
  logic [FRAME_BITS-1:0]   tx_buf;
  logic                    tx_loaded;

  logic                    start;
  logic                    last_bit;
  logic                    frame_done;
  logic [FRAME_BITS-1:0]   rx_word;

  assign start      = (state == S_IDLE) && cs_fall;
  assign last_bit   = (bit_cnt == CW'(FRAME_BITS - 1));
  assign frame_done = (state == S_ACTIVE) && !cs_rise && sclk_rise && last_bit;
  // On the final rising edge the last MOSI bit has not been shifted in yet;
  // append it directly so the word is complete on the same cycle.
  assign rx_word    = {shift[FRAME_BITS-2:0], mosi_s};

  // The shift register carries outgoing bits toward the MSB while incoming
  // bits fill from the LSB. The TX LSB still occupies shift[0] when the first
  // bit arrives, so each sampled MOSI bit waits in mosi_bit until the falling
  // edge makes room for it.
  always_ff @(posedge avmm_clk) begin
    if (avmm_reset) begin
      state    <= S_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      mosi_bit <= 1'b0;
      spi_miso <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state    <= S_ACTIVE;
            bit_cnt  <= '0;
            shift    <= tx_loaded ? tx_buf : '0;
            spi_miso <= tx_loaded & tx_buf[FRAME_BITS-1];
          end
        end
        S_ACTIVE: begin
          if (cs_rise) begin
            // Aborted frame: drop the partial word.
            state    <= S_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            spi_miso <= 1'b0;
          end else if (sclk_rise) begin
            mosi_bit <= mosi_s;
            bit_cnt  <= bit_cnt + CW'(1);
            if (last_bit) begin
              state    <= S_DONE;
              spi_miso <= 1'b0;
            end
          end else if (sclk_fall && (bit_cnt != '0)) begin
            // A falling edge before any sampled bit carries no data.
            shift    <= {shift[FRAME_BITS-2:0], mosi_bit};
            spi_miso <= shift[FRAME_BITS-2];
          end
        end
        S_DONE: begin
          if (cs_rise) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
          end
        end
        default: begin
          state    <= S_IDLE;
          spi_miso <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers and status
  // ---------------------------------------------------------------------------
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  overrun;
  logic                  underrun;
  logic [15:0]           frame_cnt;
  logic                  busy;
  logic [31:0]           rd_mux;

  assign busy = (state != S_IDLE);

  // NOTE: an always_comb block must assign every output on every path; the
  // default at the top guarantees that, so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (avmm_addr)
      ADDR_STATUS:   rd_mux = {27'd0, underrun, tx_loaded, busy, overrun, rx_valid};
      ADDR_RXDATA:   rd_mux = 32'(rx_data);
      ADDR_TXDATA:   rd_mux = '0;
      ADDR_FRAMECNT: rd_mux = {16'd0, frame_cnt};
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge avmm_clk) begin
    if (avmm_reset) begin
      tx_buf        <= '0;
      tx_loaded     <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
      underrun      <= 1'b0;
      frame_cnt     <= 16'd0;
      avmm_readdata <= 32'd0;
    end else begin
      // The shift register was loaded from the old buffer on a start cycle,
      // so a simultaneous write only affects the following frame.
      if (wr_tx) begin
        tx_buf <= avmm_writedata[FRAME_BITS-1:0];
      end

      if (wr_tx) begin
        tx_loaded <= 1'b1;
      end else if (start) begin
        tx_loaded <= 1'b0;
      end

      if (frame_done) begin
        rx_data <= rx_word;
      end

      // A completing frame wins over a concurrent RXDATA read.
      if (frame_done) begin
        rx_valid <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end

      // Set events win over a coincident write-1-to-clear. A read of RXDATA
      // in the completion cycle consumes the old word, so it is no overrun.
      if (frame_done && rx_valid && !rd_rx) begin
        overrun <= 1'b1;
      end else if (wr_status && avmm_writedata[1]) begin
        overrun <= 1'b0;
      end

      if (start && !tx_loaded) begin
        underrun <= 1'b1;
      end else if (wr_status && avmm_writedata[4]) begin
        underrun <= 1'b0;
      end

      if (wr_cnt) begin
        frame_cnt <= 16'd0;
      end else if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (rd_en) begin
        avmm_readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// -----------------------------------------------------------------------------
// tb_spi_target
//
// Drives two spi_target instances (FRAME_BITS=32 and FRAME_BITS=8) that share
// the register bus and SPI clock/data pins but have separate bus selects and
// SPI selects. A transaction-level model tracks each target's registers;
// register reads push their expected value into a queue and an independent
// monitor pops and compares whenever a read response becomes due.
// -----------------------------------------------------------------------------
module tb_spi_target;

  localparam int PH = 6;  // SPI clock half-period in avmm_clk cycles

  logic        clk = 1'b0;
  logic        avmm_reset;
  logic [1:0]  cs;
  logic [1:0]  addr;
  logic        wr;
  logic        rd;
  logic [31:0] wdata;
  logic [31:0] rdata32;
  logic [31:0] rdata8;
  logic        sclk;
  logic        mosi;
  logic [1:0]  csn;
  logic        miso32;
  logic        miso8;

  always #5 clk = ~clk;

  spi_target #(.FRAME_BITS(32)) dut32 (
    .avmm_clk      (clk),
    .avmm_reset    (avmm_reset),
    .avmm_cs       (cs[0]),
    .avmm_addr     (addr),
    .avmm_write    (wr),
    .avmm_writedata(wdata),
    .avmm_read     (rd),
    .avmm_readdata (rdata32),
    .spi_clk       (sclk),
    .spi_cs_n      (csn[0]),
    .spi_mosi      (mosi),
    .spi_miso      (miso32)
  );

  spi_target #(.FRAME_BITS(8)) dut8 (
    .avmm_clk      (clk),
    .avmm_reset    (avmm_reset),
    .avmm_cs       (cs[1]),
    .avmm_addr     (addr),
    .avmm_write    (wr),
    .avmm_writedata(wdata),
    .avmm_read     (rd),
    .avmm_readdata (rdata8),
    .spi_clk       (sclk),
    .spi_cs_n      (csn[1]),
    .spi_mosi      (mosi),
    .spi_miso      (miso8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one entry per target (0 = 32-bit, 1 = 8-bit)
  // ---------------------------------------------------------------------------
  logic [31:0] m_tx  [2];
  logic [31:0] m_rx  [2];
  logic [15:0] m_cnt [2];
  bit          m_txl [2];
  bit          m_rxv [2];
  bit          m_ovr [2];
  bit          m_und [2];
  logic [31:0] last_exp [2];

  function automatic int fbits(input int sel);
    return (sel == 1) ? 8 : 32;
  endfunction

  function automatic logic [31:0] fmask(input int sel);
    return (sel == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < 2; s++) begin
      m_tx[s] = 0; m_rx[s] = 0; m_cnt[s] = 0;
      m_txl[s] = 0; m_rxv[s] = 0; m_ovr[s] = 0; m_und[s] = 0;
    end
  endfunction

  function automatic logic [31:0] m_status(input int sel, input bit busy);
    return {27'd0, m_und[sel], m_txl[sel], busy, m_ovr[sel], m_rxv[sel]};
  endfunction

  function automatic void m_write(input int sel, input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: begin
        if (d[1]) m_ovr[sel] = 0;
        if (d[4]) m_und[sel] = 0;
      end
      2'd2: begin
        m_tx[sel]  = d & fmask(sel);
        m_txl[sel] = 1;
      end
      2'd3: m_cnt[sel] = 0;
      default: ;
    endcase
  endfunction

  // Frame start: returns the word the target should shift out.
  function automatic logic [31:0] m_start(input int sel);
    logic [31:0] e;
    if (m_txl[sel]) e = m_tx[sel];
    else begin
      e = 0;
      m_und[sel] = 1;
    end
    m_txl[sel] = 0;
    return e;
  endfunction

  function automatic void m_complete(input int sel, input logic [31:0] w, input bit same_rd);
    if (m_rxv[sel] && !same_rd) m_ovr[sel] = 1;
    m_rxv[sel] = 1;
    m_rx[sel]  = w & fmask(sel);
    m_cnt[sel] = m_cnt[sel] + 16'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard and read monitor
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q  [$];
  string       name_q [$];
  logic [1:0]  rd_acc;

  always @(posedge clk) rd_acc <= avmm_reset ? 2'b00 : (cs & {2{rd}});

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    string       nm;
    for (int d = 0; d < 2; d++) begin
      if (rd_acc[d]) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL read_unexpected dut%0d: got 0x%08h, no expected value queued",
                   d, (d == 1) ? rdata8 : rdata32);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, (d == 1) ? rdata8 : rdata32, e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks (inputs change on the falling avmm_clk edge)
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input int sel, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs[sel] = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 2'b00; wr = 1'b0;
    m_write(sel, a, d);
  endtask

  task automatic bus_read(input int sel, input logic [1:0] a, input string nm, input bit busy = 0);
    logic [31:0] e;
    case (a)
      2'd0: e = m_status(sel, busy);
      2'd1: begin
        e = m_rx[sel];
        m_rxv[sel] = 0;
      end
      2'd3: e = {16'd0, m_cnt[sel]};
      default: e = 32'd0;
    endcase
    @(negedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    last_exp[sel] = e;
    cs[sel] = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 2'b00; rd = 1'b0;
  endtask

  // One SPI bit: MOSI set during the low phase, MISO sampled just before the
  // rising edge. With rd_last, an RXDATA read is placed in the exact cycle the
  // target recognises the final rising edge (two sync flops after the pin).
  task automatic spi_bit(input int sel, input logic b, input bit rd_last, output logic mb);
    mosi = b;
    wait_clk(PH);
    mb = (sel == 1) ? miso8 : miso32;
    sclk = 1'b1;
    if (rd_last) begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      exp_q.push_back(m_rx[sel]);
      name_q.push_back("rx_read_at_completion");
      cs[sel] = 1'b1; rd = 1'b1; addr = 2'd1;
      @(negedge clk);
      cs = 2'b00; rd = 1'b0;
      wait_clk(PH - 3);
    end else begin
      wait_clk(PH);
    end
    sclk = 1'b0;
  endtask

  // abort_at < 0: full frame; otherwise spi_cs_n rises after abort_at bits.
  task automatic frame(input int sel, input logic [31:0] word, input int abort_at,
                       input bit rd_last, input bit clr_und_at_start);
    int          n = fbits(sel);
    logic [31:0] got = 32'd0;
    logic [31:0] exp_miso;
    logic        mb;
    bit          full = (abort_at < 0);
    exp_miso = m_start(sel);
    @(negedge clk);
    csn[sel] = 1'b0;
    if (clr_und_at_start) begin
      // W1C of underrun lands on the cycle the target sees the select edge.
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      cs[sel] = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 32'h10;
      @(negedge clk);
      cs = 2'b00; wr = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      if (!full && k == abort_at) break;
      spi_bit(sel, word[n-1-k], rd_last && (k == n - 1), mb);
      got[n-1-k] = mb;
    end
    wait_clk(PH);
    csn[sel] = 1'b1;
    wait_clk(PH);
    if (full) begin
      m_complete(sel, word, rd_last);
      check((sel == 1) ? "miso_word_8" : "miso_word_32", got, exp_miso);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] w;
    logic        mb;
    int          sel;

    avmm_reset = 1'b1;
    cs = 2'b00; wr = 1'b0; rd = 1'b0; addr = 2'd0; wdata = 32'd0;
    sclk = 1'b0; mosi = 1'b0; csn = 2'b11;
    m_reset();
    for (int s = 0; s < 2; s++) last_exp[s] = 0;
    wait_clk(3);
    avmm_reset = 1'b0;
    wait_clk(5);

    // Reset state
    check("reset_readdata32", rdata32, 32'd0);
    check("reset_readdata8", rdata8, 32'd0);
    check("reset_miso32", {31'd0, miso32}, 32'd0);
    bus_read(0, 2'd0, "reset_status");
    bus_read(0, 2'd1, "reset_rxdata");
    bus_read(0, 2'd3, "reset_framecnt");
    bus_read(1, 2'd0, "reset_status_8");

    // Basic frame
    bus_write(0, 2'd2, 32'h5A12_3456);
    frame(0, 32'h6881_A5C3, -1, 0, 0);
    bus_read(0, 2'd0, "basic_status");
    bus_read(0, 2'd1, "basic_rxdata");
    bus_read(0, 2'd3, "basic_framecnt");
    bus_read(0, 2'd2, "txdata_reads_zero");
    wait_clk(4);
    check("readdata_hold", rdata32, last_exp[0]);

    // Overrun: two frames, the second also underruns (no TX write)
    bus_write(0, 2'd2, $urandom);
    frame(0, $urandom, -1, 0, 0);
    frame(0, $urandom, -1, 0, 0);
    bus_read(0, 2'd0, "overrun_status");
    bus_write(0, 2'd0, 32'h2);
    bus_read(0, 2'd0, "overrun_cleared_status");
    bus_read(0, 2'd1, "overrun_rxdata");
    bus_write(0, 2'd0, 32'h10);
    bus_read(0, 2'd0, "underrun_cleared_status");

    // Underrun: no TXDATA, MISO stays 0, data still captured
    frame(0, 32'hDEAD_BEEF, -1, 0, 0);
    bus_read(0, 2'd0, "underrun_status");
    bus_read(0, 2'd1, "underrun_rxdata");
    bus_write(0, 2'd0, 32'h12);

    // Abort after 10 bits, then a good frame
    bus_write(0, 2'd2, 32'h1357_9BDF);
    frame(0, $urandom, 10, 0, 0);
    bus_read(0, 2'd0, "abort_status");
    bus_read(0, 2'd3, "abort_framecnt");
    bus_write(0, 2'd0, 32'h10);
    bus_write(0, 2'd2, 32'hA5A5_0F0F);
    frame(0, 32'h0BAD_CAFE, -1, 0, 0);
    bus_read(0, 2'd1, "after_abort_rxdata");
    bus_read(0, 2'd3, "after_abort_framecnt");

    // RXDATA read coinciding with completion while rx_valid is already set
    bus_write(0, 2'd2, $urandom);
    frame(0, $urandom, -1, 0, 0);
    bus_write(0, 2'd2, $urandom);
    frame(0, 32'h1122_3344, -1, 1, 0);
    bus_read(0, 2'd0, "same_cycle_status");
    bus_read(0, 2'd1, "same_cycle_rxdata");

    // W1C of underrun colliding with a new underrun event
    bus_write(0, 2'd0, 32'h12);
    frame(0, $urandom, -1, 0, 1);
    bus_read(0, 2'd0, "w1c_collision_status");
    bus_write(0, 2'd0, 32'h12);

    // FRAMECNT clear by any write
    bus_write(0, 2'd3, $urandom);
    bus_read(0, 2'd3, "framecnt_cleared");

    // 8-bit target
    bus_write(1, 2'd2, 32'hFFFF_FF3C);
    frame(1, 32'h0000_00A5, -1, 0, 0);
    bus_read(1, 2'd1, "rxdata_8");
    bus_read(1, 2'd0, "status_8");

    // Randomized traffic on both targets
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) bus_write(sel, 2'd2, $urandom);
      w = $urandom & fmask(sel);
      frame(sel, w, -1, 0, 0);
      if ($urandom_range(0, 2) != 0) bus_read(sel, 2'd1, "rand_rxdata");
      bus_read(sel, 2'd0, "rand_status");
      bus_read(sel, 2'd3, "rand_framecnt");
      if ($urandom_range(0, 1) == 1) bus_write(sel, 2'd0, 32'h12);
    end

    // Reset in the middle of a frame
    bus_write(0, 2'd2, 32'hCAFE_F00D);
    w = m_start(0);
    @(negedge clk);
    csn[0] = 1'b0;
    for (int k = 0; k < 10; k++) spi_bit(0, k[0], 0, mb);
    bus_read(0, 2'd0, "mid_frame_status_busy", 1);
    wait_clk(2);
    @(negedge clk);
    avmm_reset = 1'b1;
    wait_clk(2);
    check("miso_during_reset", {31'd0, miso32}, 32'd0);
    check("readdata_during_reset", rdata32, 32'd0);
    avmm_reset = 1'b0;
    m_reset();
    wait_clk(10);
    // spi_cs_n still low: clock edges must not start a frame
    for (int k = 0; k < 3; k++) spi_bit(0, 1'b1, 0, mb);
    wait_clk(PH);
    check("miso_after_reset_no_frame", {31'd0, miso32}, 32'd0);
    bus_read(0, 2'd0, "post_reset_status");
    bus_read(0, 2'd1, "post_reset_rxdata");
    bus_read(0, 2'd3, "post_reset_framecnt");
    csn[0] = 1'b1;
    wait_clk(PH);
    bus_write(0, 2'd2, 32'h0F1E_2D3C);
    frame(0, 32'h8765_4321, -1, 0, 0);
    bus_read(0, 2'd1, "post_reset_frame_rxdata");
    bus_read(0, 2'd3, "post_reset_frame_framecnt");
    bus_read(1, 2'd0, "post_reset_status_8");

    wait_clk(4);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
